aw_channel_decoder: RTL and testbench
=====================================

Name: aw_channel_decoder

Overview:
AXI4 write-address (AW) channel decoder in the interconnect, between one master-side AW port and two slave-side AW ports (M00, M01). Selects the target slave from the upper address bits, steers awvalid to it and returns that slave's awready. Broadcasts the AW payload to both slaves. Emits a registered one-hot per-slave enable for the write-data routing queue.

Parameters:
Address_width, 32, awaddr width
Base_Addr_Width, 2, number of MSBs of awaddr used as slave index
Slaves_Num, 2, number of slave ports; only 2 supported (M00, M01)
Slaves_ID_Size, 1, AW ID width
S00_Aw_len, 8, awlen width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
Master_AXI_awaddr  in  Address_width  write address
Master_AXI_awaddr_ID  in  Slaves_ID_Size  AW ID
Master_AXI_awlen  in  S00_Aw_len  burst length
Master_AXI_awsize  in  3  beat size
Master_AXI_awburst  in  2  burst type
Master_AXI_awlock  in  1  lock
Master_AXI_awcache  in  4  cache
Master_AXI_awprot  in  3  prot
Master_AXI_awqos  in  4  QoS
Master_AXI_awvalid  in  1  master valid
Master_AXI_awready  out  1  ready to master
M0x_AXI_awaddr / _awaddr_ID / _awlen / _awsize / _awburst / _awlock / _awcache / _awprot / _awqos  out  same widths as master fields  payload to slave x (x = 0, 1)
M0x_AXI_awvalid  out  1  valid to slave x
M0x_AXI_awready  in  1  ready from slave x
Q_Enables  out  Slaves_Num  registered one-hot write-data queue push, bit i = slave i
Sel_Slave_Ready  out  1  awready of the currently selected slave

Behaviour:
- sel = awaddr[Address_width-1 -: Base_Addr_Width]; hit = (sel < Slaves_Num). Examples: 0x0000_1000 gives sel 0; 0x4000_1000 gives sel 1; 0x8000_0000 and 0xC000_0000 are misses.
- All payload fields are wired combinationally to both slaves, unchanged.
- M0x_AXI_awvalid = Master_AXI_awvalid & hit & (sel == x). Never more than one slave valid at a time.
- Sel_Slave_Ready = hit ? M0{sel}_AXI_awready : 0. Master_AXI_awready = Sel_Slave_Ready.
- awvalid-to-awvalid and awready-to-awready paths are zero latency with no combinational loop (ready never depends on valid).
- Handshake = Master_AXI_awvalid & Master_AXI_awready.
- On the rising clk after a handshake, Q_Enables = one-hot(sel) for exactly 1 cycle; otherwise 0. Back-to-back handshakes give consecutive pulses.
- Miss with awvalid high: no slave valid, awready 0, so the master stalls (but see the optional feature).
- reset asserted: Q_Enables = 0 immediately (asynchronous). The combinational outputs follow their inputs during reset.
- Reset asserted in the same cycle as a handshake: no pulse is produced.

Optional Feature:
AW_DECERR_EN: adds output port Dec_Err (1 bit, sticky) and a miss-accept path.
- With the macro: on a miss with awvalid high, the decoder drives Master_AXI_awready = 1 for one cycle, accepting the transaction. Q_Enables stays 0. Dec_Err is set on the next clk and held until reset.
- Without the macro: a miss never gets awready and the Dec_Err port does not exist.

Test Plan:
- Reset held 5 cycles -> Q_Enables = 0, both slave awvalid 0 while master awvalid = 0.
- awaddr 0x0000_1000, awvalid = 1, M00 awready = 1 -> M00 awvalid = 1, M01 awvalid = 0, Master awready = 1, Q_Enables = 2'b01 for one cycle after the edge.
- awaddr 0x4000_1000, awvalid = 1, M01 awready = 1 -> M01 awvalid = 1, Q_Enables = 2'b10 for one cycle; payload (ID, len = 8'h0F, size = 3'd2, burst = 2'b01) appears on M01 unchanged.
- Backpressure: awaddr 0x0000_1000, M00 awready low 3 cycles then high -> Master awready tracks M00, and Q_Enables pulses only once, after the accept.
- Miss: awaddr 0x8000_0000 -> no slave awvalid and Master awready = 0. With AW_DECERR_EN, awready pulses and Dec_Err = 1.
- Reset asserted the same cycle as a handshake -> Q_Enables stays 0.

Source files
------------

// File: rtl/aw_channel_decoder.sv
// AXI4 AW channel decoder: routes one master AW port to slaves M00/M01 by address MSBs.
// Optional feature macro AW_DECERR_EN adds a sticky Dec_Err output and accepts missed writes.
module aw_channel_decoder #(
    parameter int unsigned Address_width   = 32,
    parameter int unsigned Base_Addr_Width = 2,
    parameter int unsigned Slaves_Num      = 2,
    parameter int unsigned Slaves_ID_Size  = 1,
    parameter int unsigned S00_Aw_len      = 8
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic [Address_width-1:0]  Master_AXI_awaddr,
    input  logic [Slaves_ID_Size-1:0] Master_AXI_awaddr_ID,
    input  logic [S00_Aw_len-1:0]     Master_AXI_awlen,
    input  logic [2:0]                Master_AXI_awsize,
    input  logic [1:0]                Master_AXI_awburst,
    input  logic                      Master_AXI_awlock,
    input  logic [3:0]                Master_AXI_awcache,
    input  logic [2:0]                Master_AXI_awprot,
    input  logic [3:0]                Master_AXI_awqos,
    input  logic                      Master_AXI_awvalid,
    output logic                      Master_AXI_awready,

    output logic [Address_width-1:0]  M00_AXI_awaddr,
    output logic [Slaves_ID_Size-1:0] M00_AXI_awaddr_ID,
    output logic [S00_Aw_len-1:0]     M00_AXI_awlen,
    output logic [2:0]                M00_AXI_awsize,
    output logic [1:0]                M00_AXI_awburst,
    output logic                      M00_AXI_awlock,
    output logic [3:0]                M00_AXI_awcache,
    output logic [2:0]                M00_AXI_awprot,
    output logic [3:0]                M00_AXI_awqos,
    output logic                      M00_AXI_awvalid,
    input  logic                      M00_AXI_awready,

    output logic [Address_width-1:0]  M01_AXI_awaddr,
    output logic [Slaves_ID_Size-1:0] M01_AXI_awaddr_ID,
    output logic [S00_Aw_len-1:0]     M01_AXI_awlen,
    output logic [2:0]                M01_AXI_awsize,
    output logic [1:0]                M01_AXI_awburst,
    output logic                      M01_AXI_awlock,
    output logic [3:0]                M01_AXI_awcache,
    output logic [2:0]                M01_AXI_awprot,
    output logic [3:0]                M01_AXI_awqos,
    output logic                      M01_AXI_awvalid,
    input  logic                      M01_AXI_awready,

    output logic [Slaves_Num-1:0]     Q_Enables,
`ifdef AW_DECERR_EN
    output logic                      Dec_Err,
`endif
    output logic                      Sel_Slave_Ready
);

    logic [Base_Addr_Width-1:0] sel;
    logic                       hit;
    logic                       sel0;
    logic                       sel1;
    logic                       handshake;
    logic [Slaves_Num-1:0]      q_enables_d;

    // Slave index comes from the top address bits; indices >= Slaves_Num are a decode miss.
    assign sel  = Master_AXI_awaddr[Address_width-1 -: Base_Addr_Width];
    assign hit  = (32'(sel) < Slaves_Num);
    assign sel0 = hit & (sel == Base_Addr_Width'(0));
    assign sel1 = hit & (sel == Base_Addr_Width'(1));

    assign M00_AXI_awaddr    = Master_AXI_awaddr;
    assign M00_AXI_awaddr_ID = Master_AXI_awaddr_ID;
    assign M00_AXI_awlen     = Master_AXI_awlen;
    assign M00_AXI_awsize    = Master_AXI_awsize;
    assign M00_AXI_awburst   = Master_AXI_awburst;
    assign M00_AXI_awlock    = Master_AXI_awlock;
    assign M00_AXI_awcache   = Master_AXI_awcache;
    assign M00_AXI_awprot    = Master_AXI_awprot;
    assign M00_AXI_awqos     = Master_AXI_awqos;

    assign M01_AXI_awaddr    = Master_AXI_awaddr;
    assign M01_AXI_awaddr_ID = Master_AXI_awaddr_ID;
    assign M01_AXI_awlen     = Master_AXI_awlen;
    assign M01_AXI_awsize    = Master_AXI_awsize;
    assign M01_AXI_awburst   = Master_AXI_awburst;
    assign M01_AXI_awlock    = Master_AXI_awlock;
    assign M01_AXI_awcache   = Master_AXI_awcache;
    assign M01_AXI_awprot    = Master_AXI_awprot;
    assign M01_AXI_awqos     = Master_AXI_awqos;

    assign M00_AXI_awvalid = Master_AXI_awvalid & sel0;
    assign M01_AXI_awvalid = Master_AXI_awvalid & sel1;

    // Ready is a function of address and slave ready only, never of awvalid.
    assign Sel_Slave_Ready = (sel0 & M00_AXI_awready) | (sel1 & M01_AXI_awready);

`ifdef AW_DECERR_EN
    // A miss is accepted locally so the master does not stall on an unmapped address.
    assign Master_AXI_awready = Sel_Slave_Ready | ~hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Dec_Err <= 1'b0;
        end else if (Master_AXI_awvalid & ~hit) begin
            Dec_Err <= 1'b1;
        end
    end
`else
    assign Master_AXI_awready = Sel_Slave_Ready;
`endif

    assign handshake = Master_AXI_awvalid & Master_AXI_awready;

    always_comb begin
        q_enables_d    = '0;
        q_enables_d[0] = handshake & sel0;
        q_enables_d[1] = handshake & sel1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q_Enables <= '0;
        end else begin
            Q_Enables <= q_enables_d;
        end
    end

endmodule

// File: tb/tb_aw_channel_decoder.sv
// Self-checking bench for aw_channel_decoder: directed scenarios plus randomized traffic
// checked against an address-map reference model.
`timescale 1ns/1ps
module tb_aw_channel_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] awaddr;
    logic [0:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic [3:0]  awqos;
    logic        awvalid;
    logic        awready;
    logic [31:0] m0_addr, m1_addr;
    logic [0:0]  m0_id, m1_id;
    logic [7:0]  m0_len, m1_len;
    logic [2:0]  m0_size, m1_size;
    logic [1:0]  m0_burst, m1_burst;
    logic        m0_lock, m1_lock;
    logic [3:0]  m0_cache, m1_cache;
    logic [2:0]  m0_prot, m1_prot;
    logic [3:0]  m0_qos, m1_qos;
    logic        m0_valid, m1_valid;
    logic        m0_ready, m1_ready;
    logic [1:0]  q_en;
    logic        sel_ready;
`ifdef AW_DECERR_EN
    logic        dec_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aw_channel_decoder dut (
        .clk                 (clk),
        .reset               (reset),
        .Master_AXI_awaddr   (awaddr),
        .Master_AXI_awaddr_ID(awid),
        .Master_AXI_awlen    (awlen),
        .Master_AXI_awsize   (awsize),
        .Master_AXI_awburst  (awburst),
        .Master_AXI_awlock   (awlock),
        .Master_AXI_awcache  (awcache),
        .Master_AXI_awprot   (awprot),
        .Master_AXI_awqos    (awqos),
        .Master_AXI_awvalid  (awvalid),
        .Master_AXI_awready  (awready),
        .M00_AXI_awaddr      (m0_addr),
        .M00_AXI_awaddr_ID   (m0_id),
        .M00_AXI_awlen       (m0_len),
        .M00_AXI_awsize      (m0_size),
        .M00_AXI_awburst     (m0_burst),
        .M00_AXI_awlock      (m0_lock),
        .M00_AXI_awcache     (m0_cache),
        .M00_AXI_awprot      (m0_prot),
        .M00_AXI_awqos       (m0_qos),
        .M00_AXI_awvalid     (m0_valid),
        .M00_AXI_awready     (m0_ready),
        .M01_AXI_awaddr      (m1_addr),
        .M01_AXI_awaddr_ID   (m1_id),
        .M01_AXI_awlen       (m1_len),
        .M01_AXI_awsize      (m1_size),
        .M01_AXI_awburst     (m1_burst),
        .M01_AXI_awlock      (m1_lock),
        .M01_AXI_awcache     (m1_cache),
        .M01_AXI_awprot      (m1_prot),
        .M01_AXI_awqos       (m1_qos),
        .M01_AXI_awvalid     (m1_valid),
        .M01_AXI_awready     (m1_ready),
        .Q_Enables           (q_en),
`ifdef AW_DECERR_EN
        .Dec_Err             (dec_err),
`endif
        .Sel_Slave_Ready     (sel_ready)
    );

    // Reference model: the address map as plain arithmetic.
    function automatic int slave_of(input logic [31:0] a);
        return int'(a >> 30);
    endfunction

    function automatic logic model_ready(input logic [31:0] a, input logic r0, input logic r1);
        int s = slave_of(a);
        if (s == 0) return r0;
        if (s == 1) return r1;
`ifdef AW_DECERR_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [1:0] model_q(input logic [31:0] a, input logic v,
                                           input logic r0, input logic r1);
        int s = slave_of(a);
        if (v && s < 2 && model_ready(a, r0, r1)) return 2'(1 << s);
        return 2'b00;
    endfunction

    // Change inputs on the falling edge, then let combinational outputs settle.
    task automatic apply(input logic [31:0] a, input logic v, input logic r0, input logic r1);
        @(negedge clk);
        awaddr   = a;
        awvalid  = v;
        m0_ready = r0;
        m1_ready = r1;
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        apply(32'h0, 1'b0, 1'b1, 1'b1);
        repeat (5) after_edge();
        checks++;
        if (q_en !== 2'b00) begin
            errors++; $display("FAIL reset_q got %b want 00", q_en);
        end
        checks++;
        if ({m0_valid, m1_valid} !== 2'b00) begin
            errors++; $display("FAIL reset_valid got %b want 00", {m0_valid, m1_valid});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_m00();
        apply(32'h0000_1000, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({m1_valid, m0_valid, awready, sel_ready} !== 4'b0111) begin
            errors++;
            $display("FAIL m00_comb got %b want 0111", {m1_valid, m0_valid, awready, sel_ready});
        end
        after_edge();
        checks++;
        if (q_en !== 2'b01) begin errors++; $display("FAIL m00_q got %b want 01", q_en); end
        apply(32'h0000_1000, 1'b0, 1'b1, 1'b0);
        after_edge();
        checks++;
        if (q_en !== 2'b00) begin errors++; $display("FAIL m00_q_clear got %b want 00", q_en); end
    endtask

    task automatic test_m01_payload();
        awid = 1'b1; awlen = 8'h0F; awsize = 3'd2; awburst = 2'b01;
        awlock = 1'b1; awcache = 4'hA; awprot = 3'd5; awqos = 4'h6;
        apply(32'h4000_1000, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({m1_valid, m0_valid, awready} !== 3'b101) begin
            errors++; $display("FAIL m01_comb got %b want 101", {m1_valid, m0_valid, awready});
        end
        checks++;
        if ({m1_addr, m1_id, m1_len, m1_size, m1_burst, m1_lock, m1_cache, m1_prot, m1_qos} !==
            {32'h4000_1000, 1'b1, 8'h0F, 3'd2, 2'b01, 1'b1, 4'hA, 3'd5, 4'h6}) begin
            errors++; $display("FAIL m01_payload got addr %h len %h size %0d burst %b",
                               m1_addr, m1_len, m1_size, m1_burst);
        end
        checks++;
        if ({m0_addr, m0_len, m0_qos} !== {32'h4000_1000, 8'h0F, 4'h6}) begin
            errors++; $display("FAIL m00_broadcast got addr %h len %h qos %h want 40001000 0f 6",
                               m0_addr, m0_len, m0_qos);
        end
        after_edge();
        checks++;
        if (q_en !== 2'b10) begin errors++; $display("FAIL m01_q got %b want 10", q_en); end
    endtask

    task automatic test_backpressure();
        int pulses = 0;
        for (int i = 0; i < 3; i++) begin
            apply(32'h0000_1000, 1'b1, 1'b0, 1'b1);
            checks++;
            if (awready !== 1'b0) begin
                errors++; $display("FAIL bp_ready_low got %b want 0", awready);
            end
            after_edge();
            if (q_en != 2'b00) pulses++;
        end
        apply(32'h0000_1000, 1'b1, 1'b1, 1'b1);
        checks++;
        if (awready !== 1'b1) begin errors++; $display("FAIL bp_ready_high got %b want 1", awready); end
        after_edge();
        checks++;
        if (q_en !== 2'b01) begin errors++; $display("FAIL bp_q got %b want 01", q_en); end
        if (q_en != 2'b00) pulses++;
        apply(32'h0000_1000, 1'b0, 1'b1, 1'b1);
        after_edge();
        if (q_en != 2'b00) pulses++;
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL bp_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_miss();
        logic exp_ready;
`ifdef AW_DECERR_EN
        exp_ready = 1'b1;
`else
        exp_ready = 1'b0;
`endif
        apply(32'h8000_0000, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({m0_valid, m1_valid, awready, sel_ready} !== {2'b00, exp_ready, 1'b0}) begin
            errors++; $display("FAIL miss_comb got %b want %b",
                               {m0_valid, m1_valid, awready, sel_ready}, {2'b00, exp_ready, 1'b0});
        end
        after_edge();
        checks++;
        if (q_en !== 2'b00) begin errors++; $display("FAIL miss_q got %b want 00", q_en); end
`ifdef AW_DECERR_EN
        checks++;
        if (dec_err !== 1'b1) begin errors++; $display("FAIL dec_err got %b want 1", dec_err); end
`endif
        apply(32'hC000_0000, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({m0_valid, m1_valid} !== 2'b00) begin
            errors++; $display("FAIL miss_c_valid got %b want 00", {m0_valid, m1_valid});
        end
        apply(32'h0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset_handshake();
        apply(32'h0000_1000, 1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        after_edge();
        checks++;
        if (q_en !== 2'b00) begin errors++; $display("FAIL rst_hs_q got %b want 00", q_en); end
        checks++;
        if (m0_valid !== 1'b1) begin
            errors++; $display("FAIL rst_comb_valid got %b want 1", m0_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        // Asynchronous clear: a live pulse must drop as soon as reset rises.
        after_edge();
        checks++;
        if (q_en !== 2'b01) begin errors++; $display("FAIL pre_async_q got %b want 01", q_en); end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (q_en !== 2'b00) begin errors++; $display("FAIL async_q got %b want 00", q_en); end
        @(negedge clk);
        reset = 1'b0;
        apply(32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [1:0]  exp_q;
        for (int i = 0; i < 4; i++) begin
            a = (i % 2 == 0) ? 32'h0000_0040 : 32'h4000_0080;
            apply(a, 1'b1, 1'b1, 1'b1);
            after_edge();
            exp_q = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (q_en !== exp_q) begin
                errors++; $display("FAIL b2b_q[%0d] got %b want %b", i, q_en, exp_q);
            end
        end
        apply(32'h0, 1'b0, 1'b0, 1'b0);
        after_edge();
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic        v, r0, r1;
        logic [1:0]  exp_q;
        logic [1:0]  exp_v;
        for (int i = 0; i < 300; i++) begin
            a  = $urandom;
            v  = 1'($urandom_range(0, 3) != 0);
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            apply(a, v, r0, r1);
            exp_v = 2'b00;
            if (v && slave_of(a) < 2) exp_v = 2'(1 << slave_of(a));
            exp_q = model_q(a, v, r0, r1);
            checks++;
            if ({m1_valid, m0_valid} !== exp_v || awready !== model_ready(a, r0, r1)) begin
                errors++; $display("FAIL rand_comb[%0d] addr %h got v %b rdy %b want v %b rdy %b",
                                   i, a, {m1_valid, m0_valid}, awready, exp_v,
                                   model_ready(a, r0, r1));
            end
            after_edge();
            checks++;
            if (q_en !== exp_q) begin
                errors++; $display("FAIL rand_q[%0d] addr %h got %b want %b", i, a, q_en, exp_q);
            end
        end
    endtask

    initial begin
        awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0; awlock = 1'b0;
        awcache = '0; awprot = '0; awqos = '0; awvalid = 1'b0; m0_ready = 1'b0; m1_ready = 1'b0;
        reset = 1'b1;
        test_reset();
        test_m00();
        test_m01_payload();
        test_backpressure();
        test_back_to_back();
        test_reset_handshake();
        test_random();
        test_miss();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
